dct_mac_engine: RTL and testbench
=================================

DCT_MAC_ENGINE -- requirements
Module: dct_mac_engine

Interface
REQ-001 Parameter N, default 8: transform points per block; SHALL be 4 or 8.
REQ-002 Parameter DATA_WIDTH, default 8: signed input sample width.
REQ-003 Parameter COEF_WIDTH, default 8: signed coefficient width.
REQ-004 Parameter FRAC_BITS, default 6: coefficient fraction bits, range 0..COEF_WIDTH-1.
REQ-005 Parameter OUT_WIDTH, default 16: signed output width.
REQ-006 clk  in  1  sole clock; all state changes on the rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 in_valid / in_ready  in / out  1 / 1  input handshake; a sample transfers on an edge where both are 1.
REQ-009 in_data  in  DATA_WIDTH  signed sample x[n]; N consecutive transfers form one block.
REQ-010 in_inv  in  1  mode select, sampled with sample 0 only: 0 = forward (C[k][n]), 1 = inverse (C[n][k]).
REQ-011 out_valid / out_ready  out / in  1 / 1  output handshake; a result transfers on an edge where both are 1.
REQ-012 out_data  out  OUT_WIDTH  signed y[k], emitted k=0..N-1 in order.
REQ-013 out_last  out  1  high with y[N-1].
REQ-014 cfg_we / cfg_addr / cfg_data  in  1 / clog2(N*N) / COEF_WIDTH  coefficient write; addr = k*N+n.
REQ-015 busy  out  1  high while any block is in input, done-pending or output state.
REQ-016 cfg_err  out  1  one-cycle pulse on a rejected cfg write.

Function
REQ-017 The coefficient table SHALL be N*N registers; a cfg_we write SHALL take effect on that edge only when busy=0.
REQ-018 A cfg_we with busy=1 SHALL leave the table unchanged and pulse cfg_err the next cycle.
REQ-019 N parallel lanes SHALL each hold one accumulator of DATA_WIDTH+COEF_WIDTH+clog2(N) bits, sign-extended, no overflow possible.
REQ-020 On transfer of sample n: lane k acc <= coef*x[n] when n=0, acc + coef*x[n] otherwise; coef = C[k][n] forward, C[n][k] inverse.
REQ-021 A sample counter SHALL run 0..N-1 and wrap to 0; transfer of sample N-1 SHALL set a done flag.
REQ-022 Result per lane: (acc + 2^(FRAC_BITS-1)) arithmetic-shifted right by FRAC_BITS (no rounding add when FRAC_BITS=0), then saturated to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-023 The N-entry output buffer SHALL load all N results on an edge where done=1 and the buffer is empty or is popping its final entry; done SHALL clear on that edge.
REQ-024 Latency: last sample transferred on edge e -> out_valid=1 with y[0] after edge e+1, when the buffer is free.
REQ-025 in_ready SHALL be 0 exactly when done=1 and the load of REQ-023 cannot occur this cycle; otherwise 1.
REQ-026 Sample 0 of the next block MAY transfer on the same edge as the buffer load; the load SHALL use the pre-edge accumulators.
REQ-027 out_data and out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-028 After y[N-1] transfers, out_valid SHALL drop unless a new load occurs on that edge.
REQ-029 The buffer SHALL drain at one result per cycle under continuous out_ready; sustained throughput SHALL be one sample per cycle.

Reset
REQ-030 rst_n low SHALL immediately clear: counter, done, buffer state, accumulators, coefficient table (all 0); out_valid=0, out_data=0, out_last=0, cfg_err=0, busy=0, in_ready=1.
REQ-031 A partial block in flight at reset SHALL be discarded; the first transfer after release SHALL be sample 0.

Verification
REQ-032 Diagonal C=64 (FRAC_BITS 6), forward, x=1..8 -> y=1..8, out_last on y=8, out_valid one cycle after last sample edge.
REQ-033 Only C[0][1]=64: forward x=0..7 -> y[0]=1, rest 0; inverse same x -> y[1]=0, y[0]=0, y[1..] per C[n][k] with y[1]=x[0]=0; repeat with x[0]=5 -> inverse y[1]=5.
REQ-034 Rounding: acc=96 -> +2; acc=-96 -> -1; FRAC_BITS=0, all C=-128, x=-128 -> 131072 saturates to 32767.
REQ-035 out_ready=0 held: block 1 buffered, block 2 completes, in_ready=0, out_data stays y0 of block 1; release -> block 1 then block 2 emitted in order, no loss.
REQ-036 cfg_we during block input -> cfg_err pulse, table unchanged; rst_n low after 3 samples -> all outputs 0, next 8 samples form a fresh block.

Source files
------------

// File: rtl/dct_mac_engine.sv
// dct_mac_engine: N-lane multiply-accumulate engine for an N-point DCT/IDCT.
// Samples stream in one per cycle. Each lane accumulates one output coefficient.
// Finished blocks are rounded, saturated and moved into an N-entry output buffer.
// The buffer drains one result per cycle and overlaps with input of the next block.
module dct_mac_engine #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 8,
    parameter int COEF_WIDTH = 8,
    parameter int FRAC_BITS  = 6,
    parameter int OUT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [DATA_WIDTH-1:0]  in_data,
    input  logic                          in_inv,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [OUT_WIDTH-1:0]   out_data,
    output logic                          out_last,
    input  logic                          cfg_we,
    input  logic [$clog2(N*N)-1:0]        cfg_addr,
    input  logic signed [COEF_WIDTH-1:0]  cfg_data,
    output logic                          busy,
    output logic                          cfg_err
);

    localparam int IW     = $clog2(N);
    localparam int AW     = $clog2(N*N);
    localparam int PW     = DATA_WIDTH + COEF_WIDTH;
    localparam int ACC_W  = PW + IW;
    // Working width for rounding: one guard bit above the accumulator, and
    // always wider than the output so the saturation bounds fit.
    localparam int SW     = (ACC_W + 1 > OUT_WIDTH) ? ACC_W + 1 : OUT_WIDTH + 1;
    localparam int RND_SH = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;
    localparam logic signed [SW-1:0] RND  = (FRAC_BITS > 0) ? (SW'(1) << RND_SH) : '0;
    localparam logic signed [SW-1:0] MAXV = {{(SW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] MINV = {{(SW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    logic signed [COEF_WIDTH-1:0] coef_reg [N*N];
    logic signed [OUT_WIDTH-1:0]  obuf_reg [N];
    logic signed [OUT_WIDTH-1:0]  lane_res [N];
    logic [IW-1:0]                cnt_reg;
    logic [IW-1:0]                rd_idx_reg;
    logic                         done_reg;
    logic                         inv_reg;
    logic                         buf_valid_reg;
    logic                         cfg_err_reg;

    logic in_fire;
    logic out_fire;
    logic buf_free;
    logic load;
    logic first_sample;
    logic cur_inv;

    // Round half up, shift down to integer scale, clamp to the output range.
    function automatic logic signed [OUT_WIDTH-1:0] round_sat(input logic signed [ACC_W-1:0] a);
        logic signed [SW-1:0] r;
        r = {{(SW-ACC_W){a[ACC_W-1]}}, a};
        r = (r + RND) >>> FRAC_BITS;
        if (r > MAXV) begin
            return MAXV[OUT_WIDTH-1:0];
        end else if (r < MINV) begin
            return MINV[OUT_WIDTH-1:0];
        end
        return r[OUT_WIDTH-1:0];
    endfunction

    // Handshake decode: the buffer accepts a finished block when empty or
    // when its last entry leaves on this same edge.
    always_comb begin
        out_fire     = buf_valid_reg && out_ready;
        buf_free     = !buf_valid_reg || (out_fire && (rd_idx_reg == LAST_IDX));
        load         = done_reg && buf_free;
        in_ready     = !(done_reg && !buf_free);
        in_fire      = in_valid && in_ready;
        first_sample = (cnt_reg == '0);
        cur_inv      = first_sample ? in_inv : inv_reg;
        busy         = (cnt_reg != '0) || done_reg || buf_valid_reg;
        out_valid    = buf_valid_reg;
        out_last     = buf_valid_reg && (rd_idx_reg == LAST_IDX);
        out_data     = buf_valid_reg ? obuf_reg[rd_idx_reg] : '0;
        cfg_err      = cfg_err_reg;
    end

    // Sample counter, block-complete flag and the mode latched with sample 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg  <= '0;
            done_reg <= 1'b0;
            inv_reg  <= 1'b0;
        end else begin
            if (in_fire) begin
                cnt_reg <= (cnt_reg == LAST_IDX) ? '0 : cnt_reg + 1'b1;
                if (first_sample) begin
                    inv_reg <= in_inv;
                end
            end
            if (load) begin
                done_reg <= 1'b0;
            end else if (in_fire && (cnt_reg == LAST_IDX)) begin
                done_reg <= 1'b1;
            end
        end
    end

    // Coefficient table: writes land only while idle, otherwise flag an error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N*N; i++) begin
                coef_reg[i] <= '0;
            end
            cfg_err_reg <= 1'b0;
        end else begin
            if (cfg_we && !busy) begin
                coef_reg[cfg_addr] <= cfg_data;
            end
            cfg_err_reg <= cfg_we && busy;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            logic [AW-1:0]               addr_fwd;
            logic [AW-1:0]               addr_inv;
            logic signed [COEF_WIDTH-1:0] coef;
            logic signed [PW-1:0]         prod;
            logic signed [ACC_W-1:0]      prod_ext;
            logic signed [ACC_W-1:0]      acc_reg;

            // Lane gi is output index k; forward uses C[k][n], inverse C[n][k].
            always_comb begin
                addr_fwd = {IW'(gi), cnt_reg};
                addr_inv = {cnt_reg, IW'(gi)};
                coef     = cur_inv ? coef_reg[addr_inv] : coef_reg[addr_fwd];
                prod     = PW'(coef) * PW'(in_data);
                prod_ext = ACC_W'(prod);
            end

            // Sample 0 restarts the sum, so a stale total never leaks into a new block.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    acc_reg <= '0;
                end else if (in_fire) begin
                    acc_reg <= first_sample ? prod_ext : acc_reg + prod_ext;
                end
            end

            assign lane_res[gi] = round_sat(acc_reg);
        end
    endgenerate

    // Output buffer: capture all lanes at once, then drain in index order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                obuf_reg[i] <= '0;
            end
            buf_valid_reg <= 1'b0;
            rd_idx_reg    <= '0;
        end else if (load) begin
            for (int i = 0; i < N; i++) begin
                obuf_reg[i] <= lane_res[i];
            end
            buf_valid_reg <= 1'b1;
            rd_idx_reg    <= '0;
        end else if (out_fire) begin
            if (rd_idx_reg == LAST_IDX) begin
                buf_valid_reg <= 1'b0;
                rd_idx_reg    <= '0;
            end else begin
                rd_idx_reg <= rd_idx_reg + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dct_mac_engine.sv
// tb_dct_mac_engine: self-checking bench for dct_mac_engine (N=8) plus a
// FRAC_BITS=0 instance for the saturation corner.
module tb_dct_mac_engine;

    localparam int N = 8;

    logic clk;
    logic rst_n;
    logic in_valid, in_ready, in_inv;
    logic out_valid, out_ready, out_last;
    logic cfg_we, busy, cfg_err;
    logic signed [7:0]  in_data;
    logic signed [15:0] out_data;
    logic [5:0]         cfg_addr;
    logic signed [7:0]  cfg_data;

    logic b_in_valid, b_in_ready, b_in_inv;
    logic b_out_valid, b_out_ready, b_out_last;
    logic b_cfg_we, b_busy, b_cfg_err;
    logic signed [7:0]  b_in_data;
    logic signed [15:0] b_out_data;
    logic [5:0]         b_cfg_addr;
    logic signed [7:0]  b_cfg_data;

    dct_mac_engine dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_inv(in_inv),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .busy(busy), .cfg_err(cfg_err)
    );

    dct_mac_engine #(.FRAC_BITS(0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_inv(b_in_inv),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_last(b_out_last),
        .cfg_we(b_cfg_we), .cfg_addr(b_cfg_addr), .cfg_data(b_cfg_data),
        .busy(b_busy), .cfg_err(b_cfg_err)
    );

    typedef struct { int d; bit l; } out_t;
    typedef struct { int c; int x0; int y0; } rnd_vec_t;

    out_t got_q[$];
    int   total = 0;
    int   bad   = 0;
    int   tb_c[64];
    bit   drv_done;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    // Capture every output transfer (inputs change only just after posedge).
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            got_q.push_back('{int'(out_data), out_last});
        end
    end

    // Reference: y[k] = sum_n C*x, round half up, floor-divide by 2^frac, clamp.
    function automatic int ref_y(input int c[64], input int x[8], input bit inv,
                                 input int frac, input int k);
        longint acc = 0;
        longint r;
        for (int n = 0; n < 8; n++) begin
            acc += longint'(inv ? c[n*8+k] : c[k*8+n]) * longint'(x[n]);
        end
        if (frac > 0) r = (acc + (longint'(1) <<< (frac-1))) >>> frac;
        else          r = acc;
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return int'(r);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        if (busy) begin
            total++; bad++;
            $display("FAIL idle_timeout: busy=%0d required 0", busy);
        end
    endtask

    task automatic cfg_write(input int a, input int v);
        wait_idle();
        cfg_we = 1'b1; cfg_addr = 6'(a); cfg_data = 8'(v);
        @(posedge clk); #1;
        cfg_we = 1'b0;
        tb_c[a] = v;
    endtask

    task automatic send_samples(input int x[8], input bit inv, input int first, input int cnt);
        int t;
        for (int n = first; n < first + cnt; n++) begin
            in_valid = 1'b1;
            in_data  = 8'(x[n]);
            in_inv   = (n == 0) ? inv : ~inv;
            t = 0;
            @(negedge clk);
            while (!in_ready && t < 1000) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) begin
                total++; bad++;
                $display("FAIL in_ready_timeout: in_ready=%0d required 1 at sample %0d", in_ready, n);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic get_block(output int d[8], output bit l[8]);
        int t;
        out_t e;
        for (int k = 0; k < 8; k++) begin
            t = 0;
            while (got_q.size() == 0 && t < 2000) begin
                @(posedge clk); #1;
                t++;
            end
            if (got_q.size() == 0) begin
                total++; bad++;
                $display("FAIL out_timeout: got no result for y[%0d], required one", k);
                d[k] = 0; l[k] = 1'b0;
            end else begin
                e = got_q.pop_front();
                d[k] = e.d; l[k] = e.l;
            end
        end
    endtask

    task automatic check_model(input string name, input int d[8], input bit l[8],
                               input int x[8], input bit inv);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("%s_y%0d", name, k), d[k], ref_y(tb_c, x, inv, 6, k));
            chk($sformatf("%s_last%0d", name, k), int'(l[k]), (k == 7) ? 1 : 0);
        end
    endtask

    initial begin
        rnd_vec_t tv[7];
        int  d[8];
        bit  l[8];
        int  x[8];
        int  x2[8];
        int  xs[4][8];
        bit  invs[4];
        int  t;

        tv[0] = '{48, 2, 2};
        tv[1] = '{-48, 2, -1};
        tv[2] = '{1, 31, 0};
        tv[3] = '{1, 32, 1};
        tv[4] = '{127, 127, 252};
        tv[5] = '{-128, 127, -254};
        tv[6] = '{-128, -128, 256};

        for (int i = 0; i < 64; i++) tb_c[i] = 0;
        rst_n = 1'b0; in_valid = 0; in_data = 0; in_inv = 0; out_ready = 1;
        cfg_we = 0; cfg_addr = 0; cfg_data = 0;
        b_in_valid = 0; b_in_data = 0; b_in_inv = 0; b_out_ready = 1;
        b_cfg_we = 0; b_cfg_addr = 0; b_cfg_data = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_cfg_err", int'(cfg_err), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // FRAC_BITS=0 instance: every C=-128, x=-128 sums to 131072 and clamps.
        for (int a = 0; a < 64; a++) begin
            b_cfg_we = 1'b1; b_cfg_addr = 6'(a); b_cfg_data = -8'sd128;
            @(posedge clk); #1;
        end
        b_cfg_we = 1'b0;
        for (int n = 0; n < 8; n++) begin
            b_in_valid = 1'b1; b_in_data = -8'sd128; b_in_inv = 1'b0;
            @(posedge clk); #1;
        end
        b_in_valid = 1'b0;
        t = 0;
        @(negedge clk);
        while (!b_out_valid && t < 100) begin @(negedge clk); t++; end
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("sat_valid%0d", k), int'(b_out_valid), 1);
            chk($sformatf("sat_y%0d", k), int'(b_out_data), 32767);
            chk($sformatf("sat_last%0d", k), int'(b_out_last), (k == 7) ? 1 : 0);
        end
        @(posedge clk); #1;

        // Rounding vectors: only C[0][0] set, only x[0] nonzero.
        for (int i = 0; i < 7; i++) begin
            cfg_write(0, tv[i].c);
            for (int n = 0; n < 8; n++) x[n] = 0;
            x[0] = tv[i].x0;
            send_samples(x, 1'b0, 0, 8);
            get_block(d, l);
            chk($sformatf("round%0d_y0", i), d[0], tv[i].y0);
            chk($sformatf("round%0d_y1", i), d[1], 0);
            chk($sformatf("round%0d_last", i), int'(l[7]), 1);
            $display("round vec %0d: C=%0d x0=%0d y0=%0d", i, tv[i].c, tv[i].x0, d[0]);
        end

        // Diagonal 64, x=1..8 forward, with first-result latency.
        for (int k = 0; k < 8; k++) cfg_write(k*9, 64);
        for (int n = 0; n < 8; n++) x[n] = n + 1;
        send_samples(x, 1'b0, 0, 8);
        chk("lat_valid_e", int'(out_valid), 0);
        @(posedge clk); #1;
        chk("lat_valid_e1", int'(out_valid), 1);
        chk("lat_y0", int'(out_data), 1);
        get_block(d, l);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("diag_y%0d", k), d[k], k + 1);
            chk($sformatf("diag_last%0d", k), int'(l[k]), (k == 7) ? 1 : 0);
        end
        $display("diag block: y0=%0d y7=%0d", d[0], d[7]);

        // Backpressure: block 1 parked in the buffer, block 2 done behind it.
        out_ready = 1'b0;
        for (int n = 0; n < 8; n++) x2[n] = n + 11;
        send_samples(x, 1'b0, 0, 8);
        send_samples(x2, 1'b0, 0, 8);
        @(negedge clk);
        chk("bp_in_ready", int'(in_ready), 0);
        chk("bp_out_valid", int'(out_valid), 1);
        chk("bp_hold_y0", int'(out_data), 1);
        repeat (5) @(negedge clk);
        chk("bp_in_ready_later", int'(in_ready), 0);
        chk("bp_hold_y0_later", int'(out_data), 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        get_block(d, l);
        for (int k = 0; k < 8; k++) chk($sformatf("bp_b1_y%0d", k), d[k], k + 1);
        get_block(d, l);
        for (int k = 0; k < 8; k++) chk($sformatf("bp_b2_y%0d", k), d[k], k + 11);
        chk("bp_b2_last", int'(l[7]), 1);
        $display("backpressure: block2 y0=%0d y7=%0d", d[0], d[7]);

        // Only C[0][1]=64: forward picks x[1] into y0, inverse x[0] into y1.
        for (int k = 0; k < 8; k++) cfg_write(k*9, 0);
        cfg_write(1, 64);
        for (int n = 0; n < 8; n++) x[n] = n;
        send_samples(x, 1'b0, 0, 8);
        get_block(d, l);
        chk("c01_fwd_y0", d[0], 1);
        check_model("c01_fwd", d, l, x, 1'b0);
        send_samples(x, 1'b1, 0, 8);
        get_block(d, l);
        chk("c01_inv_y1", d[1], 0);
        check_model("c01_inv", d, l, x, 1'b1);
        x[0] = 5;
        send_samples(x, 1'b1, 0, 8);
        get_block(d, l);
        chk("c01_inv5_y1", d[1], 5);
        chk("c01_inv5_y0", d[0], 0);
        check_model("c01_inv5", d, l, x, 1'b1);
        $display("c01 inverse x0=5: y1=%0d", d[1]);

        // cfg write during block input is refused and flagged.
        for (int n = 0; n < 8; n++) x[n] = $urandom_range(0, 255) - 128;
        send_samples(x, 1'b0, 0, 3);
        cfg_we = 1'b1; cfg_addr = 6'd1; cfg_data = 8'sd0;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        chk("cfgerr_pulse", int'(cfg_err), 1);
        chk("cfgerr_busy", int'(busy), 1);
        @(posedge clk); #1;
        chk("cfgerr_clear", int'(cfg_err), 0);
        send_samples(x, 1'b0, 3, 5);
        get_block(d, l);
        chk("cfgerr_table_kept", d[0], x[1]);
        check_model("cfgerr", d, l, x, 1'b0);

        // Randomized: random tables, random blocks and modes, random out_ready.
        for (int ph = 0; ph < 3; ph++) begin
            for (int a = 0; a < 64; a++) cfg_write(a, int'($urandom_range(0, 255)) - 128);
            for (int b = 0; b < 4; b++) begin
                for (int n = 0; n < 8; n++) xs[b][n] = int'($urandom_range(0, 255)) - 128;
                invs[b] = 1'($urandom_range(0, 1));
            end
            drv_done = 1'b0;
            fork
                begin
                    int xb[8];
                    for (int b = 0; b < 4; b++) begin
                        for (int n = 0; n < 8; n++) xb[n] = xs[b][n];
                        send_samples(xb, invs[b], 0, 8);
                    end
                    drv_done = 1'b1;
                end
                begin
                    int tr = 0;
                    while ((!drv_done || got_q.size() < 32) && tr < 5000) begin
                        @(posedge clk); #1;
                        out_ready = 1'($urandom_range(0, 1));
                        tr++;
                    end
                    out_ready = 1'b1;
                end
            join
            for (int b = 0; b < 4; b++) begin
                for (int n = 0; n < 8; n++) x[n] = xs[b][n];
                get_block(d, l);
                check_model($sformatf("rand%0d_%0d", ph, b), d, l, x, invs[b]);
                $display("random phase %0d block %0d inv=%0d y0=%0d", ph, b, invs[b], d[0]);
            end
        end

        // Reset in the middle of a block with a result parked in the buffer.
        for (int k = 0; k < 64; k++) if (tb_c[k] != 0) cfg_write(k, 0);
        for (int k = 0; k < 8; k++) cfg_write(k*9, 64);
        out_ready = 1'b0;
        for (int n = 0; n < 8; n++) x[n] = n + 1;
        send_samples(x, 1'b0, 0, 8);
        t = 0;
        while (!out_valid && t < 100) begin @(posedge clk); #1; t++; end
        chk("prerst_out_valid", int'(out_valid), 1);
        send_samples(x, 1'b0, 0, 3);
        chk("prerst_busy", int'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", int'(out_valid), 0);
        chk("mrst_out_data", int'(out_data), 0);
        chk("mrst_out_last", int'(out_last), 0);
        chk("mrst_cfg_err", int'(cfg_err), 0);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 64; i++) tb_c[i] = 0;
        out_ready = 1'b1;
        send_samples(x, 1'b0, 0, 8);
        get_block(d, l);
        check_model("postrst_zero", d, l, x, 1'b0);
        for (int k = 0; k < 8; k++) cfg_write(k*9, 64);
        for (int n = 0; n < 8; n++) x[n] = 8 - n;
        send_samples(x, 1'b0, 0, 8);
        get_block(d, l);
        for (int k = 0; k < 8; k++) chk($sformatf("postrst_y%0d", k), d[k], 8 - k);
        chk("postrst_last", int'(l[7]), 1);
        $display("post reset block: y0=%0d y7=%0d", d[0], d[7]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
